// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: buffers {rx_error, rx_data} entries for a consumer
// with registered pop output, occupancy count and a sticky overrun flag.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          rx_error,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_err,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          overrun_clr
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    rd_data_q;
  logic          rd_err_q, rd_valid_q, overrun_q, overrun_d;
  logic          do_write, do_read, lost_byte;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign do_read   = rd_en && !empty;
  assign do_write  = rx_done && (!full || rd_en);
  assign lost_byte = rx_done && full && !rd_en;

  always_comb begin
    count_d = count_q;
    unique case ({do_write, do_read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A new loss wins over a coincident clear.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (lost_byte)   overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= {rx_error, rx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= 8'h00;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= do_read;
      if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_read) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem[rd_ptr_q][7:0];
        rd_err_q  <= mem[rd_ptr_q][8];
      end
    end
  end

  assign count    = count_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign rd_valid = rd_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: hand-computed expectations checked with immediate assertions.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done, rx_error, rd_en, overrun_clr;
  logic [7:0] rd_data;
  logic       rd_err, rd_valid, empty, full, overrun;
  logic [4:0] count;

  int n_vec  = 0;
  int n_miss = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_error    (rx_error),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    rx_done  = 1'b1;
    rx_data  = d;
    rx_error = e;
    tick();
    rx_done  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; rx_error = 1'b0;
    rd_en = 1'b0; overrun_clr = 1'b0;
    #12;
    check("rst_count",   16'(count),    16'd0);
    check("rst_empty",   16'(empty),    16'd1);
    check("rst_full",    16'(full),     16'd0);
    check("rst_rdvalid", 16'(rd_valid), 16'd0);
    check("rst_rddata",  16'(rd_data),  16'h00);
    check("rst_overrun", 16'(overrun),  16'd0);
    #1 rst_n = 1'b1;

    // Single byte through; write lands on the first edge after reset release.
    push(8'hA5, 1'b0);
    check("a5_count1", 16'(count), 16'd1);
    check("a5_empty0", 16'(empty), 16'd0);
    pop();
    check("a5_valid",  16'(rd_valid), 16'd1);
    check("a5_data",   16'(rd_data),  16'hA5);
    check("a5_err",    16'(rd_err),   16'd0);
    check("a5_count0", 16'(count),    16'd0);
    check("a5_empty1", 16'(empty),    16'd1);
    tick();
    check("a5_valid_drop", 16'(rd_valid), 16'd0);

    // Fill, overflow with 0xFF, drain in order.
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    check("fill_full",    16'(full),    16'd1);
    check("fill_count",   16'(count),   16'd16);
    check("fill_overrun", 16'(overrun), 16'd0);
    push(8'hFF, 1'b0);
    check("ovf_count",   16'(count),   16'd16);
    check("ovf_overrun", 16'(overrun), 16'd1);
    for (int i = 0; i < 16; i++) begin
      pop();
      check("drain_data", 16'(rd_data), 16'(i));
    end
    check("drain_empty",   16'(empty),   16'd1);
    check("drain_overrun", 16'(overrun), 16'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_clear", 16'(overrun), 16'd0);

    // Simultaneous write and read while full.
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
    rx_done = 1'b1; rx_data = 8'h55; rd_en = 1'b1;
    tick();
    rx_done = 1'b0; rd_en = 1'b0;
    check("wr_rd_full_count",   16'(count),    16'd16);
    check("wr_rd_full_overrun", 16'(overrun),  16'd0);
    check("wr_rd_full_valid",   16'(rd_valid), 16'd1);
    check("wr_rd_full_data",    16'(rd_data),  16'h10);
    for (int i = 1; i < 16; i++) begin
      pop();
      check("wr_rd_drain", 16'(rd_data), 16'(8'h10 + i));
    end
    pop();
    check("wr_rd_last55", 16'(rd_data), 16'h55);

    // Error flag preserved with its byte.
    push(8'h3C, 1'b1);
    pop();
    check("err_data", 16'(rd_data), 16'h3C);
    check("err_flag", 16'(rd_err),  16'd1);

    // Simultaneous write and read while empty: read ignored, no bypass.
    rx_done = 1'b1; rx_data = 8'h77; rd_en = 1'b1;
    tick();
    rx_done = 1'b0; rd_en = 1'b0;
    check("wr_rd_empty_count", 16'(count),    16'd1);
    check("wr_rd_empty_valid", 16'(rd_valid), 16'd0);
    check("wr_rd_empty_data",  16'(rd_data),  16'h3C);
    pop();
    check("wr_rd_empty_pop", 16'(rd_data), 16'h77);
    check("wr_rd_empty_err", 16'(rd_err),  16'd0);

    // rd_en held while empty.
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid", 16'(rd_valid), 16'd0);
      check("idle_data",  16'(rd_data),  16'h77);
      check("idle_count", 16'(count),    16'd0);
    end
    rd_en = 1'b0;

    // Clear coincident with a fresh overrun keeps the flag set.
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0);
    rx_done = 1'b1; rx_data = 8'hEE; overrun_clr = 1'b1;
    tick();
    rx_done = 1'b0; overrun_clr = 1'b0;
    check("clr_vs_ovr", 16'(overrun), 16'd1);
    for (int i = 0; i < 9; i++) pop();
    check("mid_count7", 16'(count),   16'd7);
    check("mid_data",   16'(rd_data), 16'h28);

    // Asynchronous reset mid-operation.
    #2 rst_n = 1'b0;
    #1;
    check("arst_count",   16'(count),   16'd0);
    check("arst_empty",   16'(empty),   16'd1);
    check("arst_overrun", 16'(overrun), 16'd0);
    check("arst_rddata",  16'(rd_data), 16'h00);
    #1 rst_n = 1'b1;
    push(8'h9A, 1'b0);
    check("post_rst_count", 16'(count), 16'd1);
    pop();
    check("post_rst_data",  16'(rd_data), 16'h9A);
    check("post_rst_empty", 16'(empty),   16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
